// File: rtl/spi_master_cfg_pkg.sv
// Shared types and constants for the configurable SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PH_A,
    PH_B,
    HOLD
  } state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_cfg_if.sv
// Sequencer-side start/ready/done handshake of the SPI master.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 2
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              cpol;
  logic              cpha;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              ready;

  modport master (
    output start, tx_data, cpol, cpha, cs_sel,
    input  rx_data, done, ready
  );

  modport slave (
    input  start, tx_data, cpol, cpha, cs_sel,
    output rx_data, done, ready
  );
endinterface

// File: rtl/spi_master_cfg_clk_gen.sv
// Half-period timer: pulses tick_o for one cycle every CLK_DIV cycles while enabled.
module spi_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero while disabled so every phase starts a full half-period.
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, selectable chip select and CS setup/hold spacing.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 50,
  parameter int NUM_CS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_cfg_if.slave   bus,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] CS_n
);
  localparam int CS_W  = cs_width(NUM_CS);
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [DATA_W-2:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              done_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [NUM_CS-1:0] cs_dec;
  logic              tick;

  // Out-of-range selects leave every line deasserted.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
    assign cs_dec[gi] = (bus.cs_sel != CS_W'(gi));
  end

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= bus.cpol;
          mosi_q <= 1'b0;
          cs_n_q <= '1;
          if (bus.start) begin
            cpol_q  <= bus.cpol;
            cpha_q  <= bus.cpha;
            tx_q    <= bus.tx_data[DATA_W-2:0];
            mosi_q  <= bus.tx_data[DATA_W-1];
            rx_q    <= '0;
            bit_q   <= '0;
            cs_n_q  <= cs_dec;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state_q <= PH_A;
        end
        PH_A: begin
          if (tick) begin
            state_q <= PH_B;
            sclk_q  <= ~cpol_q;
            if (!cpha_q) begin
              rx_q <= {rx_q[DATA_W-2:0], MISO};
            end else if (bit_q != '0) begin
              // Bit 0 was already driven during SETUP.
              mosi_q <= tx_q[DATA_W-2];
              tx_q   <= tx_q << 1;
            end
          end
        end
        PH_B: begin
          if (tick) begin
            sclk_q <= cpol_q;
            bit_q  <= bit_q + 1'b1;
            if (cpha_q) rx_q <= {rx_q[DATA_W-2:0], MISO};
            if (bit_q == LAST_BIT) begin
              state_q <= HOLD;
            end else begin
              state_q <= PH_A;
              if (!cpha_q) begin
                mosi_q <= tx_q[DATA_W-2];
                tx_q   <= tx_q << 1;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            rx_data_q <= rx_q;
            cs_n_q    <= '1;
            mosi_q    <= 1'b0;
            sclk_q    <= cpol_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign CS_n        = cs_n_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.ready   = (state_q == IDLE);

endmodule
